// File: rtl/ctrl_encode_def.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// funct codes and the mux/ALU select values used by the datapath.
package ctrl_encode_def;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_LUI = 4'd8;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;
  localparam logic [1:0] GPR_RA = 2'b10;

  // Instruction-class one-hots plus the operand selects that go with them.
  typedef struct packed {
    logic rtype;
    logic itype_alu;
    logic load;
    logic store;
    logic branch;
    logic bne;
    logic jump;
    logic jal;
    logic jr;
    logic illegal;
    logic alu_src_a;
    logic alu_src_b;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to class one-hots, ALU
// function, operand selects and immediate extension mode.
module mc_decode
  import ctrl_encode_def::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec,
  output logic [3:0] alu_op,
  output logic       ext_op
);

  always_comb begin
    dec    = '0;
    alu_op = ALU_NOP;
    ext_op = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec.rtype = 1'b1;
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          FUNCT_SLL: begin alu_op = ALU_SLL; dec.alu_src_a = 1'b1; end
          FUNCT_SRL: begin alu_op = ALU_SRL; dec.alu_src_a = 1'b1; end
          FUNCT_JR:  begin dec.rtype = 1'b0; dec.jr = 1'b1; end
          default:   begin dec.rtype = 1'b0; dec.illegal = 1'b1; end
        endcase
      end
      OP_ADDI: begin dec.itype_alu = 1'b1; dec.alu_src_b = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; end
      OP_ORI:  begin dec.itype_alu = 1'b1; dec.alu_src_b = 1'b1; alu_op = ALU_OR;  end
      OP_LUI:  begin dec.itype_alu = 1'b1; dec.alu_src_b = 1'b1; alu_op = ALU_LUI; end
      OP_LW:   begin dec.load  = 1'b1; dec.alu_src_b = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; end
      OP_SW:   begin dec.store = 1'b1; dec.alu_src_b = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1; end
      // Branches compare A-B; the sign-extended offset feeds the NPC unit.
      OP_BEQ:  begin dec.branch = 1'b1; alu_op = ALU_SUB; ext_op = 1'b1; end
      OP_BNE:  begin dec.branch = 1'b1; dec.bne = 1'b1; alu_op = ALU_SUB; ext_op = 1'b1; end
      OP_J:    dec.jump = 1'b1;
      OP_JAL:  dec.jal  = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: state register plus state/IR-decoded
// datapath enables and mux selects.
module mc_ctrl
  import ctrl_encode_def::*;
#(
  parameter int RA_IDX = 31
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic [1:0] NPCOp,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       EXTOp,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       illegal,
  output logic [2:0] state_o
);

  // GPRSel=10 selects RA_IDX in the datapath; reject indices outside the file.
  if (RA_IDX < 0 || RA_IDX > 31) begin : g_ra_range
    $error("mc_ctrl: RA_IDX must be a register index 0..31");
  end

  state_t     state_q, state_d;
  dec_t       dec;
  logic [3:0] alu_op;
  logic       ext_op;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, illegal_c;

  mc_decode u_decode (
    .op     (op),
    .funct  (funct),
    .dec    (dec),
    .alu_op (alu_op),
    .ext_op (ext_op)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_IF;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    NPCOp       = NPC_PLUS4;
    IorD        = 1'b0;
    GPRSel      = GPR_RD;
    WDSel       = WD_ALUOUT;
    EXTOp       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 1'b0;
    ALUOp       = ALU_NOP;
    case (state_q)
      S_IF: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        state_d    = S_ID;
      end
      S_ID: begin
        state_d = S_EXE;
        if (dec.jump || dec.jal) begin
          pc_write_c = 1'b1;
          NPCOp      = NPC_JUMP;
          state_d    = S_IF;
        end
        // PC was already advanced in S_IF, so the link value is PC+4.
        if (dec.jal) begin
          reg_write_c = 1'b1;
          GPRSel      = GPR_RA;
          WDSel       = WD_PC;
        end
        if (dec.jr) begin
          pc_write_c = 1'b1;
          NPCOp      = NPC_JR;
          state_d    = S_IF;
        end
        if (dec.illegal) begin
          illegal_c = 1'b1;
          state_d   = S_IF;
        end
      end
      S_EXE: begin
        ALUSrcA = dec.alu_src_a;
        ALUSrcB = dec.alu_src_b;
        EXTOp   = ext_op;
        ALUOp   = alu_op;
        if (dec.branch) begin
          pc_write_c = dec.bne ? ~zero : zero;
          NPCOp      = NPC_BRANCH;
          state_d    = S_IF;
        end else if (dec.load || dec.store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        IorD = 1'b1;
        if (dec.store) begin
          mem_write_c = 1'b1;
          state_d     = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        if (dec.load) begin
          WDSel  = WD_MDR;
          GPRSel = GPR_RT;
        end else if (dec.itype_alu) begin
          GPRSel = GPR_RT;
        end else if (dec.rtype) begin
          GPRSel = GPR_RD;
        end
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset holds state at S_IF, whose fetch enables must not fire until released.
  assign PCWrite  = pc_write_c  & rstn;
  assign IRWrite  = ir_write_c  & rstn;
  assign MemWrite = mem_write_c & rstn;
  assign RegWrite = reg_write_c & rstn;
  assign illegal  = illegal_c   & rstn;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and random instructions checked cycle by cycle
// against an instruction-level model of the control sequence.
module tb_mc_ctrl;
  import ctrl_encode_def::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] op, funct;
  logic       zero;
  logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, ALUSrcA, ALUSrcB, illegal;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [3:0] ALUOp;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  mc_ctrl #(.RA_IDX(31)) dut (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero),
    .PCWrite(PCWrite), .NPCOp(NPCOp), .IRWrite(IRWrite), .IorD(IorD),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .GPRSel(GPRSel), .WDSel(WDSel),
    .EXTOp(EXTOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal(illegal), .state_o(state_o)
  );

  typedef enum int {C_R, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_ILL} cls_t;
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    cls_t       cls;
    logic [3:0] alu;
    logic       ext;
    logic       sa;
    logic       sb;
    logic       neg;
  } ins_t;

  ins_t tbl[17];
  int   tests = 0;
  int   fails = 0;

  function automatic ins_t mk(string n, logic [5:0] o, logic [5:0] f, cls_t c,
                              logic [3:0] a, logic e, logic sa, logic sb, logic ng);
    ins_t t;
    t.name = n; t.op = o; t.funct = f; t.cls = c; t.alu = a;
    t.ext = e; t.sa = sa; t.sb = sb; t.neg = ng;
    return t;
  endfunction

  function automatic ins_t classify(logic [5:0] o, logic [5:0] f);
    ins_t r = mk("illegal", o, f, C_ILL, ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i])
      if (tbl[i].op == o && (o != 6'h00 || tbl[i].funct == f)) r = tbl[i];
    return r;
  endfunction

  function automatic int n_cycles(cls_t c);
    case (c)
      C_LW:                 return 5;
      C_R, C_IALU, C_SW:    return 4;
      C_BR:                 return 3;
      default:              return 2;
    endcase
  endfunction

  // Visited states: IF, ID, then EXE, then MEM for memory ops, then WB.
  function automatic logic [2:0] state_at(cls_t c, int k);
    if (k == 0) return 3'd0;
    if (k == 1) return 3'd1;
    if (k == 2) return 3'd2;
    if (k == 3 && (c == C_LW || c == C_SW)) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [21:0] pack(logic [2:0] st, logic pcw, logic [1:0] npc, logic irw,
                                       logic iord, logic memw, logic regw, logic [1:0] gpr,
                                       logic [1:0] wd, logic ext, logic sa, logic sb,
                                       logic [3:0] alu, logic ill);
    return {st, pcw, npc, irw, iord, memw, regw, gpr, wd, ext, sa, sb, alu, ill};
  endfunction

  function automatic logic [21:0] obs_vec();
    return pack(state_o, PCWrite, NPCOp, IRWrite, IorD, MemWrite, RegWrite, GPRSel, WDSel,
                EXTOp, ALUSrcA, ALUSrcB, ALUOp, illegal);
  endfunction

  function automatic logic [21:0] expect_vec(ins_t i, int k, logic z);
    logic [2:0] st = state_at(i.cls, k);
    logic pcw = 0, irw = 0, iord = 0, memw = 0, regw = 0, ext = 0, sa = 0, sb = 0, ill = 0;
    logic [1:0] npc = 2'b00, gpr = 2'b00, wd = 2'b00;
    logic [3:0] alu = 4'd0;
    case (st)
      3'd0: begin pcw = 1; irw = 1; end
      3'd1: begin
        if (i.cls == C_J || i.cls == C_JAL) begin pcw = 1; npc = 2'b10; end
        if (i.cls == C_JAL) begin regw = 1; gpr = 2'b10; wd = 2'b10; end
        if (i.cls == C_JR) begin pcw = 1; npc = 2'b11; end
        if (i.cls == C_ILL) ill = 1;
      end
      3'd2: begin
        alu = i.alu; ext = i.ext; sa = i.sa; sb = i.sb;
        if (i.cls == C_BR) begin pcw = i.neg ? !z : z; npc = 2'b01; end
      end
      3'd3: begin iord = 1; memw = (i.cls == C_SW); end
      default: begin
        regw = 1;
        if (i.cls == C_LW) begin wd = 2'b01; gpr = 2'b01; end
        if (i.cls == C_IALU) gpr = 2'b01;
      end
    endcase
    return pack(st, pcw, npc, irw, iord, memw, regw, gpr, wd, ext, sa, sb, alu, ill);
  endfunction

  task automatic check(string tag, logic [21:0] o, logic [21:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Entered just after a rising edge with the DUT in S_IF.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf);
    ins_t ins = classify(o, f);
    int   n   = n_cycles(ins.cls);
    logic z;
    op = o;
    funct = f;
    for (int k = 0; k < n; k++) begin
      if (zf >= 0 && state_at(ins.cls, k) == 3'd2) z = zf[0];
      else z = 1'($urandom_range(0, 1));
      zero = z;
      @(negedge clk);
      check($sformatf("%s c%0d", ins.name, k), obs_vec(), expect_vec(ins, k, z));
      @(posedge clk);
      #1;
    end
    $display("[TB] %s op=%h funct=%h zf=%0d cycles=%0d", ins.name, o, f, zf, n);
  endtask

  task automatic run_idx(input int idx, input int zf);
    run_instr(tbl[idx].op, tbl[idx].funct, zf);
  endtask

  initial begin
    ins_t sw_i;
    logic [5:0] ro, rf;
    tbl[0]  = mk("add",  OP_RTYPE, FUNCT_ADD, C_R,    ALU_ADD, 0, 0, 0, 0);
    tbl[1]  = mk("sub",  OP_RTYPE, FUNCT_SUB, C_R,    ALU_SUB, 0, 0, 0, 0);
    tbl[2]  = mk("and",  OP_RTYPE, FUNCT_AND, C_R,    ALU_AND, 0, 0, 0, 0);
    tbl[3]  = mk("or",   OP_RTYPE, FUNCT_OR,  C_R,    ALU_OR,  0, 0, 0, 0);
    tbl[4]  = mk("slt",  OP_RTYPE, FUNCT_SLT, C_R,    ALU_SLT, 0, 0, 0, 0);
    tbl[5]  = mk("sll",  OP_RTYPE, FUNCT_SLL, C_R,    ALU_SLL, 0, 1, 0, 0);
    tbl[6]  = mk("srl",  OP_RTYPE, FUNCT_SRL, C_R,    ALU_SRL, 0, 1, 0, 0);
    tbl[7]  = mk("jr",   OP_RTYPE, FUNCT_JR,  C_JR,   ALU_NOP, 0, 0, 0, 0);
    tbl[8]  = mk("addi", OP_ADDI,  6'h00,     C_IALU, ALU_ADD, 1, 0, 1, 0);
    tbl[9]  = mk("ori",  OP_ORI,   6'h00,     C_IALU, ALU_OR,  0, 0, 1, 0);
    tbl[10] = mk("lui",  OP_LUI,   6'h00,     C_IALU, ALU_LUI, 0, 0, 1, 0);
    tbl[11] = mk("lw",   OP_LW,    6'h00,     C_LW,   ALU_ADD, 1, 0, 1, 0);
    tbl[12] = mk("sw",   OP_SW,    6'h00,     C_SW,   ALU_ADD, 1, 0, 1, 0);
    tbl[13] = mk("beq",  OP_BEQ,   6'h00,     C_BR,   ALU_SUB, 1, 0, 0, 0);
    tbl[14] = mk("bne",  OP_BNE,   6'h00,     C_BR,   ALU_SUB, 1, 0, 0, 1);
    tbl[15] = mk("j",    OP_J,     6'h00,     C_J,    ALU_NOP, 0, 0, 0, 0);
    tbl[16] = mk("jal",  OP_JAL,   6'h00,     C_JAL,  ALU_NOP, 0, 0, 0, 0);

    // Reset held low across two edges with a jal on the IR inputs.
    rstn = 1'b0; op = OP_JAL; funct = 6'h00; zero = 1'b1;
    #12 check("reset_a", obs_vec(), 22'd0);
    #10 check("reset_b", obs_vec(), 22'd0);
    #5  rstn = 1'b1;

    run_idx(0, -1);
    run_idx(11, -1);
    run_idx(12, -1);
    run_idx(13, 1);
    run_idx(13, 0);
    run_idx(14, 1);
    run_idx(14, 0);
    run_idx(16, -1);
    run_idx(7, -1);
    run_instr(6'h3F, 6'h00, -1);
    run_instr(OP_RTYPE, 6'h3F, -1);
    run_idx(5, -1);
    run_idx(10, -1);
    run_idx(9, -1);
    run_idx(15, -1);

    // Abort a sw by asserting reset during its S_MEM cycle.
    op = OP_SW; funct = 6'($urandom_range(0, 63));
    sw_i = classify(op, funct);
    for (int k = 0; k < 4; k++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("sw_abort c%0d", k), obs_vec(), expect_vec(sw_i, k, zero));
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #2 rstn = 1'b0;
    #1 check("reset_mid_mem", obs_vec(), 22'd0);
    @(posedge clk);
    #1 check("reset_hold", obs_vec(), 22'd0);
    rstn = 1'b1;
    $display("[TB] sw aborted by reset in S_MEM");

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        int idx = $urandom_range(0, 16);
        ro = tbl[idx].op;
        rf = (ro == OP_RTYPE) ? tbl[idx].funct : 6'($urandom_range(0, 63));
      end else begin
        ro = 6'($urandom_range(0, 63));
        rf = 6'($urandom_range(0, 63));
      end
      run_instr(ro, rf, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
